serial_sub: RTL and testbench

Bit-serial full subtractor: computes D = A − B − bi over WIDTH clock cycles, LSB first, using one full-subtractor cell and a registered borrow. It is the subtracting counterpart of the team's combinational full-adder cell, trading area for latency. It sits beside the adder cells in the lab2 arithmetic datapath and is driven by a start/done handshake from the controlling FSM.

---
 rtl/serial_sub_if.sv | 33 +++
 rtl/serial_sub.sv | 128 ++++++++++++
 tb/tb_serial_sub.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/done handshake and operand/result bundle for serial_sub.
// SERIAL_SUB_OVF_EN adds the ov result signal.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             ov;
`endif

    modport master (
        output start, A, B, bi,
        input  busy, done, D, bo
`ifdef SERIAL_SUB_OVF_EN
        , input ov
`endif
    );

    modport slave (
        input  start, A, B, bi,
        output busy, done, D, bo
`ifdef SERIAL_SUB_OVF_EN
        , output ov
`endif
    );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial full subtractor D = A - B - bi, LSB first, one bit per clock.
// Optional SERIAL_SUB_OVF_EN adds a registered two's-complement overflow flag (ov).
module serial_sub #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    serial_sub_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] d_q;
    logic             br;
    logic             bo_q;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             busy_c;
    logic             done_c;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_nxt;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy_c = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // One full-subtractor cell; br carries the borrow between successive bits.
    assign a_bit  = ra[0];
    assign b_bit  = rb[0];
    assign d_bit  = a_bit ^ b_bit ^ br;
    assign br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);

    always_ff @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            d_q  <= '0;
            bo_q <= 1'b0;
        end else if (accept) begin
            ra   <= bus.A;
            rb   <= bus.B;
            br   <= bus.bi;
            cnt  <= '0;
            d_q  <= '0;
            bo_q <= 1'b0;
        end else if (state == SHIFT) begin
            ra  <= {1'b0, ra[WIDTH-1:1]};
            rb  <= {1'b0, rb[WIDTH-1:1]};
            br  <= br_nxt;
            cnt <= cnt + 1'b1;
            d_q <= {d_bit, d_q[WIDTH-1:1]};
            if (last) bo_q <= br_nxt;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic sa;
    logic sb;
    logic ov_q;

    // The MSB of D is produced on the last shift, so ov is resolved on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa   <= 1'b0;
            sb   <= 1'b0;
            ov_q <= 1'b0;
        end else if (accept) begin
            sa   <= bus.A[WIDTH-1];
            sb   <= bus.B[WIDTH-1];
            ov_q <= 1'b0;
        end else if (last) begin
            ov_q <= (sa != sb) && (d_bit != sa);
        end
    end

    assign bus.ov = ov_q;
`endif

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.D    = d_q;
    assign bus.bo   = bo_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - randomized and directed checks of serial_sub at WIDTH=8 and WIDTH=5.
module tb_serial_sub;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(8)) i8 ();
    serial_sub_if #(.WIDTH(5)) i5 ();

    serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(i8));
    serial_sub #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(i5));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launches one operation on both instances and checks timing, results and hold.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [4:0] a5, input logic [4:0] b5, input logic c5);
        int r8, r5, n, lat8, lat5, busy8, busy5, dn8, dn5;
        logic got8, got5, bo8, bo5;
        logic [7:0] d8;
        logic [4:0] d5;
`ifdef SERIAL_SUB_OVF_EN
        logic ov8, ov5;
`endif
        r8 = int'(a) - int'(b) - int'(c);
        r5 = int'(a5) - int'(b5) - int'(c5);
        @(negedge clk);
        i8.start = 1'b1; i8.A = a;  i8.B = b;  i8.bi = c;
        i5.start = 1'b1; i5.A = a5; i5.B = b5; i5.bi = c5;
        @(negedge clk);
        i8.start = 1'b0; i5.start = 1'b0;
        i8.A = 8'($urandom); i8.B = 8'($urandom); i8.bi = 1'($urandom);
        i5.A = 5'($urandom); i5.B = 5'($urandom); i5.bi = 1'($urandom);
        chk("clear_d8", i8.D, 0);
        chk("clear_bo8", i8.bo, 0);
        got8 = 0; got5 = 0; n = 1; lat8 = 0; lat5 = 0;
        busy8 = 0; busy5 = 0; dn8 = 0; dn5 = 0;
        d8 = 0; d5 = 0; bo8 = 0; bo5 = 0;
`ifdef SERIAL_SUB_OVF_EN
        ov8 = 0; ov5 = 0;
`endif
        while (!(got8 && got5) && n < 40) begin
            busy8 += int'(i8.busy); busy5 += int'(i5.busy);
            dn8 += int'(i8.done);   dn5 += int'(i5.done);
            if (i8.done && !got8) begin
                got8 = 1; lat8 = n; d8 = i8.D; bo8 = i8.bo;
`ifdef SERIAL_SUB_OVF_EN
                ov8 = i8.ov;
`endif
            end
            if (i5.done && !got5) begin
                got5 = 1; lat5 = n; d5 = i5.D; bo5 = i5.bo;
`ifdef SERIAL_SUB_OVF_EN
                ov5 = i5.ov;
`endif
            end
            @(negedge clk);
            n++;
        end
        chk("done_seen8", got8, 1);
        chk("done_seen5", got5, 1);
        chk("latency8", lat8, 9);
        chk("latency5", lat5, 6);
        chk("busy_cycles8", busy8, 9);
        chk("busy_cycles5", busy5, 6);
        chk("done_pulses8", dn8, 1);
        chk("done_pulses5", dn5, 1);
        chk("d8", d8, 32'(r8 & 8'hFF));
        chk("bo8", bo8, (r8 < 0) ? 1 : 0);
        chk("d5", d5, 32'(r5 & 5'h1F));
        chk("bo5", bo5, (r5 < 0) ? 1 : 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("ov8", ov8, ((a[7] != b[7]) && (r8[7] != a[7])) ? 1 : 0);
        chk("ov5", ov5, ((a5[4] != b5[4]) && (r5[4] != a5[4])) ? 1 : 0);
`endif
        chk("idle_busy8", i8.busy, 0);
        chk("hold_d8", i8.D, 32'(d8));
        chk("hold_bo8", i8.bo, 32'(bo8));
        chk("hold_d5", i5.D, 32'(d5));
    endtask

    initial begin
        int ndone, last_t;
        rst = 1'b1;
        i8.start = 0; i8.A = 0; i8.B = 0; i8.bi = 0;
        i5.start = 0; i5.A = 0; i5.B = 0; i5.bi = 0;
        repeat (3) @(negedge clk);
        i8.start = 1'b1;
        @(negedge clk);
        chk("rst_busy", i8.busy, 0);
        chk("rst_done", i8.done, 0);
        chk("rst_d", i8.D, 0);
        chk("rst_bo", i8.bo, 0);
        i8.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", i8.busy, 0);

        run_op(8'h50, 8'h20, 1'b0, 5'h14, 5'h06, 1'b0);
        run_op(8'h20, 8'h50, 1'b0, 5'h06, 5'h14, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 5'h00, 5'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 5'h1F, 5'h1F, 1'b0);
        run_op(8'h00, 8'hFF, 1'b1, 5'h00, 5'h1F, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
        run_op(8'h80, 8'h01, 1'b0, 5'h10, 5'h01, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 5'h0F, 5'h01, 1'b0);
`endif

        // start held high: extra requests ignored, operand changes after acceptance ignored
        @(negedge clk);
        i8.start = 1'b1; i8.A = 8'h05; i8.B = 8'h03; i8.bi = 1'b0;
        ndone = 0; last_t = -1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (i8.done) begin
                chk("held_d", i8.D, 8'h02);
                chk("held_bo", i8.bo, 0);
                if (last_t >= 0) chk("held_period", k - last_t, 10);
                last_t = k;
                ndone++;
                i8.A = 8'h05;
            end else if (i8.busy) begin
                i8.A = 8'($urandom);
            end
        end
        i8.start = 1'b0;
        chk("held_count", ndone, 4);
        repeat (12) @(negedge clk);

        // reset during SHIFT cycle 4
        i8.start = 1'b1; i8.A = 8'hFF; i8.B = 8'h00; i8.bi = 1'b0;
        i5.start = 1'b1; i5.A = 5'h1F; i5.B = 5'h00; i5.bi = 1'b0;
        @(negedge clk);
        i8.start = 1'b0; i5.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", i8.busy, 0);
        chk("mid_rst_done", i8.done, 0);
        chk("mid_rst_d", i8.D, 0);
        chk("mid_rst_bo", i8.bo, 0);
        chk("mid_rst_busy5", i5.busy, 0);
        run_op(8'h0F, 8'h01, 1'b0, 5'h0F, 5'h01, 1'b0);

        for (int t = 0; t < 1000; t++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom),
                   5'($urandom), 5'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
